// File: rtl/frame_buffer_writer_if.sv
// Plot-request stream and stallable memory write port of the frame buffer writer.
// The slave modport is the writer's view; the master modport is the environment's view.
interface frame_buffer_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_x;
  logic [8:0]  in_y;
  logic [5:0]  in_colour;
  logic [16:0] mem_addr;
  logic [5:0]  mem_data;
  logic        mem_we;
  logic        mem_ready;

  modport slave (
    input  in_valid, in_x, in_y, in_colour, mem_ready,
    output in_ready, mem_addr, mem_data, mem_we
  );

  modport master (
    output in_valid, in_x, in_y, in_colour, mem_ready,
    input  in_ready, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/frame_buffer_writer.sv
// Buffers (x,y,colour) plot requests in a small FIFO and writes them to linear
// video memory through a stallable write port; also performs full-screen clears.
module frame_buffer_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned H_RES      = 320,
  parameter int unsigned V_RES      = 240
) (
  input  logic                  clk,
  input  logic                  resetn,
  frame_buffer_writer_if.slave  bus,
  input  logic                  clear_req,
  input  logic [5:0]            clear_colour,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  clear_done,
  output logic [7:0]            drop_count
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [16:0] LAST_ADDR = 17'(H_RES * V_RES - 1);
  localparam logic [8:0]  H_LIM     = 9'(H_RES);
  localparam logic [8:0]  V_LIM     = 9'(V_RES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CLEAR
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] fifo_mem_q [FIFO_DEPTH];
  logic [23:0] fifo_mem_d [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        clear_pending_q, clear_pending_d;
  logic [5:0]  clear_colour_q, clear_colour_d;
  logic [16:0] mem_addr_q, mem_addr_d;
  logic [5:0]  mem_data_q, mem_data_d;
  logic        mem_we_q, mem_we_d;
  logic        frame_done_q, frame_done_d;
  logic        clear_done_q, clear_done_d;
  logic [7:0]  drop_count_q, drop_count_d;

  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        wr_done;
  logic        out_free;
  logic [23:0] head;
  logic [8:0]  head_x;
  logic [8:0]  head_y;
  logic [5:0]  head_c;
  logic        head_in_range;
  logic [16:0] head_addr;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign bus.in_ready = !fifo_full && !clear_pending_q;
  assign push         = bus.in_valid && bus.in_ready;
  assign wr_done      = mem_we_q && bus.mem_ready;
  assign out_free     = !mem_we_q || bus.mem_ready;

  assign head          = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign head_x        = head[23:15];
  assign head_y        = head[14:6];
  assign head_c        = head[5:0];
  assign head_in_range = (head_x < H_LIM) && (head_y < V_LIM);

  // y*320 as (y<<8)+(y<<6) avoids a multiplier for the standard width.
  assign head_addr = (H_RES == 320) ?
                     ({8'd0, head_y} << 8) + ({8'd0, head_y} << 6) + {8'd0, head_x} :
                     ({8'd0, head_y} * 17'(H_RES)) + {8'd0, head_x};

  always_comb begin
    state_d         = state_q;
    fifo_mem_d      = fifo_mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    clear_pending_d = clear_pending_q;
    clear_colour_d  = clear_colour_q;
    mem_addr_d      = mem_addr_q;
    mem_data_d      = mem_data_q;
    mem_we_d        = mem_we_q;
    frame_done_d    = 1'b0;
    clear_done_d    = 1'b0;
    drop_count_d    = drop_count_q;

    if (push) begin
      fifo_mem_d[wr_ptr_q[AW-1:0]] = {bus.in_x, bus.in_y, bus.in_colour};
      wr_ptr_d                     = wr_ptr_q + 1'b1;
    end

    if (wr_done) begin
      mem_we_d = 1'b0;
      if (state_q != ST_CLEAR && mem_addr_q == LAST_ADDR) frame_done_d = 1'b1;
    end

    // A clear taken while draining only re-latches the colour; it must not
    // override the DRAIN->CLEAR hand-over below.
    if (clear_req && state_q != ST_CLEAR) begin
      clear_pending_d = 1'b1;
      clear_colour_d  = clear_colour;
      if (state_q == ST_IDLE) state_d = ST_DRAIN;
    end

    case (state_q)
      ST_IDLE, ST_DRAIN: begin
        if (!fifo_empty && out_free) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (head_in_range) begin
            mem_addr_d = head_addr;
            mem_data_d = head_c;
            mem_we_d   = 1'b1;
          end else if (drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
          end
        end
        if (state_q == ST_DRAIN && fifo_empty && !mem_we_q) begin
          state_d    = ST_CLEAR;
          mem_addr_d = '0;
          mem_data_d = clear_colour_d;
          mem_we_d   = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (wr_done) begin
          if (mem_addr_q == LAST_ADDR) begin
            state_d         = ST_IDLE;
            clear_pending_d = 1'b0;
            clear_done_d    = 1'b1;
          end else begin
            mem_addr_d = mem_addr_q + 17'd1;
            mem_we_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      clear_pending_q <= 1'b0;
      clear_colour_q  <= '0;
      mem_addr_q      <= '0;
      mem_data_q      <= '0;
      mem_we_q        <= 1'b0;
      frame_done_q    <= 1'b0;
      clear_done_q    <= 1'b0;
      drop_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      fifo_mem_q      <= fifo_mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      clear_pending_q <= clear_pending_d;
      clear_colour_q  <= clear_colour_d;
      mem_addr_q      <= mem_addr_d;
      mem_data_q      <= mem_data_d;
      mem_we_q        <= mem_we_d;
      frame_done_q    <= frame_done_d;
      clear_done_q    <= clear_done_d;
      drop_count_q    <= drop_count_d;
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_we   = mem_we_q;
  assign frame_done   = frame_done_q;
  assign clear_done   = clear_done_q;
  assign drop_count   = drop_count_q;
  assign busy         = !fifo_empty || mem_we_q || (state_q != ST_IDLE) || clear_pending_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Scoreboard bench for frame_buffer_writer: the stimulus pushes expected writes,
// a negedge monitor pops and compares each completed memory write.
module tb_frame_buffer_writer;
  logic       clk;
  logic       resetn;
  logic       clear_req;
  logic [5:0] clear_colour;
  logic       busy;
  logic       frame_done;
  logic       clear_done;
  logic [7:0] drop_count;

  frame_buffer_writer_if bus ();

  frame_buffer_writer #(
    .FIFO_DEPTH (4),
    .H_RES      (320),
    .V_RES      (240)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .busy         (busy),
    .frame_done   (frame_done),
    .clear_done   (clear_done),
    .drop_count   (drop_count)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  frame_cnt = 0;
  int  clear_cnt = 0;
  int  last_addr = -1;
  int  cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Monitor: a write completes on the edge following a negedge with mem_we & mem_ready.
  always @(negedge clk) begin
    if (frame_done) begin
      frame_cnt++;
      chk("frame_done_addr", last_addr, 76799);
    end
    if (clear_done) clear_cnt++;
    if (bus.mem_we && bus.mem_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected got addr=%0d data=%0h exp none", bus.mem_addr, bus.mem_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (int'(bus.mem_addr) !== e.addr || int'(bus.mem_data) !== e.data) begin
          bad++;
          $display("FAIL write got addr=%0d data=%0h exp addr=%0d data=%0h",
                   bus.mem_addr, bus.mem_data, e.addr, e.data);
        end
      end
      last_addr = int'(bus.mem_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input int x, input int y, input int c);
    wr_t e;
    if (x < 320 && y < 240) begin
      e.addr = y * 320 + x;
      e.data = c;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_pixel(input int x, input int y, input int c);
    logic acc;
    int   n;
    bus.in_valid  = 1'b1;
    bus.in_x      = x[8:0];
    bus.in_y      = y[8:0];
    bus.in_colour = c[5:0];
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
    else expect_write(x, y, c);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx;
    int   t0;
    int   n;
    logic seen;
    logic acc;

    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_colour = '0;
    bus.mem_ready = 1'b0;
    clear_req     = 1'b0;
    clear_colour  = '0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    chk("rst_mem_we", int'(bus.mem_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_addr", int'(bus.mem_addr), 0);
    chk("rst_drop", int'(drop_count), 0);

    // Single pixel: accepted at edge N, mem_we high after edge N+1.
    bus.mem_ready = 1'b1;
    send_pixel(5, 2, 6'h2A);
    chk("lat_we_n", int'(bus.mem_we), 0);
    tick();
    chk("lat_we_n1", int'(bus.mem_we), 1);
    chk("lat_addr", int'(bus.mem_addr), 645);
    chk("lat_data", int'(bus.mem_data), 6'h2A);
    wait_idle();

    // Out-of-range requests, then saturation of the drop counter.
    send_pixel(320, 0, 1);
    send_pixel(0, 240, 2);
    send_pixel(511, 511, 3);
    wait_idle();
    chk("drop_3", int'(drop_count), 3);
    for (int i = 0; i < 297; i++) send_pixel(400 + (i % 100), i % 240, i % 64);
    wait_idle();
    chk("drop_sat", int'(drop_count), 255);

    // Back-pressure: one pixel reaches the output stage, four fill the FIFO.
    bus.mem_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      bus.in_valid  = 1'b1;
      bus.in_x      = 9'(10 + idx);
      bus.in_y      = 9'd100;
      bus.in_colour = 6'(idx + 1);
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      if (acc) begin
        expect_write(10 + idx, 100, idx + 1);
        idx++;
      end
    end
    chk("bp_accepts", idx, 5);
    chk("bp_in_ready", int'(bus.in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_addr", int'(bus.mem_addr), 32010);
      chk("bp_hold_data", int'(bus.mem_data), 1);
      chk("bp_hold_we", int'(bus.mem_we), 1);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.mem_ready = 1'b1;
    for (int i = 5; i < 8; i++) send_pixel(10 + i, 100, i + 1);
    wait_idle();

    // Last raster row streams at one pixel per cycle and ends the frame.
    t0 = cyc;
    for (int x = 0; x < 320; x++) send_pixel(x, 239, x % 64);
    chk("row_cycles", cyc - t0, 320);
    wait_idle();
    tick();
    chk("frame_cnt", frame_cnt, 1);

    // Clear with three pixels queued behind a stalled write port.
    bus.mem_ready = 1'b0;
    send_pixel(1, 1, 6'h11);
    send_pixel(2, 1, 6'h12);
    send_pixel(3, 1, 6'h13);
    clear_req    = 1'b1;
    clear_colour = 6'h3F;
    tick();
    clear_req    = 1'b0;
    clear_colour = 6'h00;
    chk("clr_in_ready", int'(bus.in_ready), 0);
    for (int a = 0; a < 76800; a++) begin
      wr_t e;
      e.addr = a;
      e.data = 6'h3F;
      exp_q.push_back(e);
    end
    bus.mem_ready = 1'b1;
    repeat (50) tick();
    clear_req    = 1'b1;
    clear_colour = 6'h01;
    tick();
    clear_req = 1'b0;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 80000) begin
      tick();
      seen = clear_done;
      n++;
    end
    chk("clr_done_seen", int'(seen), 1);
    chk("clr_queue", exp_q.size(), 0);
    tick();
    chk("clr_done_pulse", int'(clear_done), 0);
    chk("clr_in_ready_back", int'(bus.in_ready), 1);
    chk("clr_busy", int'(busy), 0);
    chk("clr_cnt", clear_cnt, 1);

    // Reset in the middle of a clear aborts it at once.
    clear_req    = 1'b1;
    clear_colour = 6'h15;
    tick();
    clear_req = 1'b0;
    for (int a = 0; a <= 1000; a++) begin
      wr_t e;
      e.addr = a;
      e.data = 6'h15;
      exp_q.push_back(e);
    end
    n = 0;
    while (!(bus.mem_we && bus.mem_addr == 17'd1000) && n < 2000) begin
      tick();
      n++;
    end
    chk("mid_clr_reach", int'(bus.mem_addr), 1000);
    resetn = 1'b0;
    tick();
    chk("mid_rst_we", int'(bus.mem_we), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_addr", int'(bus.mem_addr), 0);
    chk("mid_rst_data", int'(bus.mem_data), 0);
    chk("mid_rst_drop", int'(drop_count), 0);
    chk("mid_rst_clr_done", int'(clear_done), 0);
    resetn = 1'b1;
    repeat (5) tick();
    chk("post_rst_we", int'(bus.mem_we), 0);
    chk("post_rst_ready", int'(bus.in_ready), 1);
    chk("final_queue", exp_q.size(), 0);
    chk("final_frame_cnt", frame_cnt, 1);
    chk("final_clear_cnt", clear_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
